interrupt_ctrl: RTL and testbench
=================================

# interrupt_ctrl

Interrupt controller for the CPU core: holds the IF (0xFF0F) and IE (0xFFFF) registers and the IME flag, and arbitrates the five interrupt sources by fixed priority. It hands the CPU sequencer a dispatch request, then delivers the 3-bit vector index that drives the PC block's `int_pc_in` input. The index expands to 0x40 + 8·index. The block also provides the HALT wake condition.

## Interface
Parameters:
- `NUM_IRQ`, 5: number of interrupt sources (VBlank=0, LCD STAT=1, Timer=2, Serial=3, Joypad=4). Fixed at 5; not intended for override.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_req`  in  5  per-source request pulses; bit n high for any cycle sets IF[n].
- `if_wr`  in  1  write `wr_data[4:0]` into IF.
- `ie_wr`  in  1  write `wr_data[7:0]` into IE.
- `wr_data`  in  8  CPU write data.
- `if_rd`  out  8  `{3'b111, IF[4:0]}`.
- `ie_rd`  out  8  IE[7:0].
- `ime_ei`  in  1  EI executed (delayed enable).
- `ime_di`  in  1  DI executed.
- `ime_reti`  in  1  RETI executed (immediate enable).
- `instr_boundary`  in  1  one-cycle pulse; CPU is at an opcode-fetch boundary.
- `int_ack`  in  1  one-cycle pulse; CPU is loading PC from the interrupt vector this cycle.
- `int_req`  out  1  dispatch request to the CPU sequencer.
- `int_vec`  out  3  vector index to the PC block's `int_pc_in`.
- `int_cancel`  out  1  dispatch was cancelled; CPU loads PC with zero instead.
- `ime`  out  1  current IME.
- `wake`  out  1  `(IE[4:0] & IF[4:0]) != 0`, combinational, independent of IME.

## Operation
- Pending vector: `P = IE[4:0] & IF[4:0]`. Priority: lowest set bit wins.
- FSM states: IDLE and REQ.
  - IDLE → REQ: on `instr_boundary` when IME=1 and P≠0. `int_req` goes high the next cycle.
  - REQ → IDLE: on `int_ack`.
  - `instr_boundary` is ignored while in REQ.
- On `int_ack` in REQ:
  - P is re-evaluated in that same cycle.
  - If P≠0: `int_vec` ← index of the lowest set bit of P; that IF bit is cleared; IME ← 0; `int_cancel` ← 0.
  - If P=0 (IE or IF changed during the request window): `int_vec` is held; `int_cancel` ← 1; IME ← 0; no IF bit is cleared.
- `int_vec` and `int_cancel` are registered. They hold their values until the next `int_ack`.
- `int_ack` while in IDLE is ignored; no state changes.
- IF update precedence within one cycle, lowest to highest: hold, then `if_wr`, then ack-clear, then `irq_req`. A new request on the same bit always survives a write or an ack-clear.
- IME and the EI delay flag (`ei_pend`):
  - `ime_di` clears both IME and `ei_pend`. It wins over `ime_ei` and `ime_reti` in the same cycle.
  - `ime_reti` sets IME on the next edge.
  - `ime_ei` sets `ei_pend`.
  - On the next `instr_boundary` with `ei_pend`=1: IME ← 1 and `ei_pend` ← 0. The dispatch check at that same boundary uses the old IME=0, so the earliest dispatch is at the following boundary.
  - `int_ack` clearing IME takes priority over `ime_reti` and EI promotion in the same cycle.
- IE stores all 8 bits. Only bits [4:0] participate in P.

## Timing
- Reset (asynchronous, immediate): IF=0 (`if_rd`=0xE0), IE=0, IME=0, `ei_pend`=0, state=IDLE, `int_req`=0, `int_vec`=0, `int_cancel`=0, `wake`=0.
- A reset assertion during REQ drops `int_req` immediately. No IF bit is cleared.
- Cycle-level latencies:
  - `irq_req` pulse at cycle t: IF bit visible on `if_rd` and `wake` at t+1.
  - Boundary at t with the condition met: `int_req`=1 from t+1 until the cycle after `int_ack`.
  - `int_ack` at t: `int_vec`, `int_cancel`, IF, and IME are updated at t+1, and `int_req`=0 at t+1.
  - `if_wr` / `ie_wr` at t: new value visible at t+1.

## Test plan
- Reset, then IE=0x1F, IME set via RETI, `irq_req`=0x14, boundary, ack → `int_req` rises one cycle after the boundary; `int_vec`=2; IF becomes 0x10 (`if_rd`=0xF0); IME=0; `int_req`=0 after the ack.
- EI, then boundary B1 with IE=IF=0x01 → no `int_req` at B1 and `ime`=1 after B1; boundary B2 → `int_req`=1, ack gives `int_vec`=0.
- In REQ with P=0x08, write IE=0x00 before the ack → after the ack `int_cancel`=1, IF still 0x08, IME=0.
- Same cycle: `if_wr` with data 0x00 and `irq_req`=0x01 → IF=0x01 afterwards. Ack-clear of bit 0 coinciding with `irq_req[0]` → IF[0] stays 1.
- IME=0, IE=0x04, `irq_req[2]` pulse → `wake`=1 next cycle; a boundary produces no `int_req`.
- Assert `reset` mid-REQ → `int_req`, `ime`, and `int_vec` are 0 immediately and `if_rd`=0xE0; after release, a boundary with IE=0 yields no request.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: IF/IE registers, IME flag with delayed EI, fixed-priority
// interrupt arbitration and a two-state dispatch handshake with the CPU
// sequencer. Also exposes the HALT wake condition.
module interrupt_ctrl #(
  parameter int NUM_IRQ = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               if_wr,
  input  logic               ie_wr,
  input  logic [7:0]         wr_data,
  output logic [7:0]         if_rd,
  output logic [7:0]         ie_rd,
  input  logic               ime_ei,
  input  logic               ime_di,
  input  logic               ime_reti,
  input  logic               instr_boundary,
  input  logic               int_ack,
  output logic               int_req,
  output logic [2:0]         int_vec,
  output logic               int_cancel,
  output logic               ime,
  output logic               wake
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [4:0]   if_bits;
  logic [4:0]   if_next;
  logic [7:0]   ie_bits;
  logic         ime_next;
  logic         ei_pend;
  logic         ei_pend_next;
  logic [4:0]   pending;
  logic         any_pending;
  logic [2:0]   win_idx;
  logic         dispatch;
  logic         ack_take;

  // Index of the lowest set bit; VBlank (bit 0) has the highest priority.
  function automatic logic [2:0] lowest_idx(input logic [4:0] v);
    logic [2:0] r;
    if (v[0]) begin
      r = 3'd0;
    end else if (v[1]) begin
      r = 3'd1;
    end else if (v[2]) begin
      r = 3'd2;
    end else if (v[3]) begin
      r = 3'd3;
    end else if (v[4]) begin
      r = 3'd4;
    end else begin
      r = 3'd0;
    end
    return r;
  endfunction

  assign pending     = ie_bits[4:0] & if_bits;
  assign any_pending = (pending != 5'd0);
  assign win_idx     = lowest_idx(pending);
  // The dispatch check deliberately uses the registered IME, so an EI
  // promotion at this boundary only enables dispatch at the next one.
  assign dispatch    = (state == ST_IDLE) && instr_boundary && ime && any_pending;
  assign ack_take    = (state == ST_REQ) && int_ack;

  assign if_rd   = {3'b111, if_bits};
  assign ie_rd   = ie_bits;
  assign int_req = (state == ST_REQ);
  assign wake    = any_pending;

  // Dispatch handshake state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: boundary starts a request, acknowledge ends it.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (dispatch) begin
          next_state = ST_REQ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_REQ;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // IF next value: hold < CPU write < ack-clear < new request.
  always_comb begin
    if_next = if_bits;
    if (if_wr) begin
      if_next = wr_data[4:0];
    end else begin
      if_next = if_bits;
    end
    if (ack_take && any_pending) begin
      if_next[win_idx] = 1'b0;
    end else begin
      if_next = if_next;
    end
    if_next = if_next | irq_req;
  end

  // IME / EI-delay next values; DI dominates, then ack clears IME last.
  always_comb begin
    ime_next     = ime;
    ei_pend_next = ei_pend;
    if (ime_di) begin
      ime_next     = 1'b0;
      ei_pend_next = 1'b0;
    end else begin
      if (ime_reti) begin
        ime_next = 1'b1;
      end else begin
        ime_next = ime;
      end
      if (instr_boundary && ei_pend) begin
        ime_next     = 1'b1;
        ei_pend_next = 1'b0;
      end else begin
        ei_pend_next = ei_pend;
      end
      if (ime_ei) begin
        ei_pend_next = 1'b1;
      end else begin
        ei_pend_next = ei_pend_next;
      end
      if (ack_take) begin
        ime_next = 1'b0;
      end else begin
        ime_next = ime_next;
      end
    end
  end

  // IF, IE, IME and EI-pending registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_bits <= 5'd0;
      ie_bits <= 8'd0;
      ime     <= 1'b0;
      ei_pend <= 1'b0;
    end else begin
      if_bits <= if_next;
      if (ie_wr) begin
        ie_bits <= wr_data;
      end
      ime     <= ime_next;
      ei_pend <= ei_pend_next;
    end
  end

  // Vector / cancel result, captured on each accepted acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_vec    <= 3'd0;
      int_cancel <= 1'b0;
    end else if (ack_take) begin
      if (any_pending) begin
        int_vec    <= win_idx;
        int_cancel <= 1'b0;
      end else begin
        int_cancel <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scoreboard bench for interrupt_ctrl: stimulus pushes the expected dispatch
// result on each acknowledge, a monitor compares when the ack completes.
module tb_interrupt_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] irq_req;
  logic       if_wr;
  logic       ie_wr;
  logic [7:0] wr_data;
  logic [7:0] if_rd;
  logic [7:0] ie_rd;
  logic       ime_ei;
  logic       ime_di;
  logic       ime_reti;
  logic       instr_boundary;
  logic       int_ack;
  logic       int_req;
  logic [2:0] int_vec;
  logic       int_cancel;
  logic       ime;
  logic       wake;

  typedef struct packed {
    logic [2:0] vec;
    logic       cancel;
    logic [7:0] ifr;
    logic       ime;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic ack_seen;

  interrupt_ctrl #(.NUM_IRQ(5)) dut (
    .clock(clock), .reset(reset), .irq_req(irq_req), .if_wr(if_wr),
    .ie_wr(ie_wr), .wr_data(wr_data), .if_rd(if_rd), .ie_rd(ie_rd),
    .ime_ei(ime_ei), .ime_di(ime_di), .ime_reti(ime_reti),
    .instr_boundary(instr_boundary), .int_ack(int_ack), .int_req(int_req),
    .int_vec(int_vec), .int_cancel(int_cancel), .ime(ime), .wake(wake)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    irq_req = 5'd0; if_wr = 1'b0; ie_wr = 1'b0; wr_data = 8'd0;
    ime_ei = 1'b0; ime_di = 1'b0; ime_reti = 1'b0;
    instr_boundary = 1'b0; int_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clr();
  endtask

  task automatic expect_ack(input logic [2:0] v, input logic c, input logic [7:0] f);
    exp_t e;
    e.vec = v; e.cancel = c; e.ifr = f; e.ime = 1'b0;
    exp_q.push_back(e);
    int_ack = 1'b1;
    step();
  endtask

  // Monitor: an ack taken while int_req is high completes a dispatch.
  always @(posedge clock) begin
    exp_t e;
    ack_seen = int_ack && int_req && !reset;
    if (ack_seen) begin
      #2;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_int_vec", int_vec, e.vec);
        check("sb_int_cancel", int_cancel, e.cancel);
        check("sb_if_rd", if_rd, e.ifr);
        check("sb_ime", ime, e.ime);
        check("sb_int_req_low", int_req, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset = 1'b1;
    #1;
    check("rst_if_rd", if_rd, 8'hE0);
    check("rst_ie_rd", ie_rd, 8'h00);
    check("rst_ime", ime, 0);
    check("rst_int_req", int_req, 0);
    check("rst_int_vec", int_vec, 0);
    check("rst_int_cancel", int_cancel, 0);
    check("rst_wake", wake, 0);
    #1 reset = 1'b0;

    // T1: basic dispatch, priority picks Timer over Joypad
    ie_wr = 1'b1; wr_data = 8'h1F; step();
    check("t1_ie_rd", ie_rd, 8'h1F);
    ime_reti = 1'b1; step();
    check("t1_ime_reti", ime, 1);
    irq_req = 5'h14; step();
    check("t1_if_rd", if_rd, 8'hF4);
    check("t1_wake", wake, 1);
    instr_boundary = 1'b1; step();
    check("t1_int_req", int_req, 1);
    expect_ack(3'd2, 1'b0, 8'hF0);

    // T3: cancel when IE is cleared during the request window
    if_wr = 1'b1; wr_data = 8'h00; step();
    ie_wr = 1'b1; wr_data = 8'h08; irq_req = 5'h08; ime_reti = 1'b1; step();
    instr_boundary = 1'b1; step();
    check("t3_int_req", int_req, 1);
    ie_wr = 1'b1; wr_data = 8'h00; step();
    expect_ack(3'd2, 1'b1, 8'hE8);

    // T2: EI delay, dispatch only at the second boundary
    if_wr = 1'b1; wr_data = 8'h00; step();
    ie_wr = 1'b1; wr_data = 8'h01; irq_req = 5'h01; step();
    ime_ei = 1'b1; step();
    check("t2_ime_after_ei", ime, 0);
    instr_boundary = 1'b1; step();
    check("t2_no_req_b1", int_req, 0);
    check("t2_ime_after_b1", ime, 1);
    instr_boundary = 1'b1; step();
    check("t2_req_b2", int_req, 1);
    expect_ack(3'd0, 1'b0, 8'hE0);

    // T4: request beats write, and beats ack-clear
    if_wr = 1'b1; wr_data = 8'h00; irq_req = 5'h01; step();
    check("t4_wr_vs_irq", if_rd, 8'hE1);
    ime_reti = 1'b1; step();
    instr_boundary = 1'b1; step();
    check("t4_int_req", int_req, 1);
    irq_req = 5'h01;
    expect_ack(3'd0, 1'b0, 8'hE1);
    ime_ei = 1'b1; ime_di = 1'b1; step();
    instr_boundary = 1'b1; step();
    check("t4_di_wins", ime, 0);
    check("t4_no_req_ime0", int_req, 0);

    // T5: wake is independent of IME
    ie_wr = 1'b1; wr_data = 8'h04; if_wr = 1'b1; irq_req = 5'h04; step();
    check("t5_if_rd", if_rd, 8'hE4);
    check("t5_wake", wake, 1);
    instr_boundary = 1'b1; step();
    check("t5_no_req", int_req, 0);

    // T6: reset in the middle of a request
    ime_reti = 1'b1; step();
    instr_boundary = 1'b1; step();
    expect_ack(3'd2, 1'b0, 8'hE0);
    irq_req = 5'h04; ime_reti = 1'b1; step();
    instr_boundary = 1'b1; step();
    check("t6_int_req", int_req, 1);
    check("t6_ime_before", ime, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_int_req", int_req, 0);
    check("t6_rst_ime", ime, 0);
    check("t6_rst_int_vec", int_vec, 0);
    check("t6_rst_if_rd", if_rd, 8'hE0);
    step();
    reset = 1'b0;
    irq_req = 5'h01; ime_reti = 1'b1; step();
    instr_boundary = 1'b1; step();
    check("t6_ie0_no_req", int_req, 0);
    check("t6_ie0_no_wake", wake, 0);
    check("t6_ime_reti", ime, 1);

    step();
    step();
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
